// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, time record and counter limits for the stopwatch.
package stopwatch_pkg;

    localparam int STATE_W = 3;
    localparam int CS_MAX  = 99;
    localparam int SEC_MAX = 59;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        SPLIT  = 3'd2,
        STOP   = 3'd3,
        RECALL = 3'd4
    } state_t;

    typedef struct packed {
        logic [5:0] min;
        logic [5:0] sec;
        logic [6:0] ms_10;
    } time_t;

endpackage

// File: rtl/stopwatch_timebase.sv
// stopwatch_timebase: prescaler plus min/sec/centisecond counters; clr zeroes all, en advances.
module stopwatch_timebase
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 100000,
    parameter int MIN_MAX  = 59
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  logic  clr,
    output time_t t
);

    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] pre;
    logic          tick;

    assign tick = en && (pre == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            t   <= '0;
        end else if (clr) begin
            pre <= '0;
            t   <= '0;
        end else if (en) begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
                if (t.ms_10 == 7'(CS_MAX)) begin
                    t.ms_10 <= '0;
                    if (t.sec == 6'(SEC_MAX)) begin
                        t.sec <= '0;
                        t.min <= (t.min == 6'(MIN_MAX)) ? '0 : t.min + 1'b1;
                    end else begin
                        t.sec <= t.sec + 1'b1;
                    end
                end else begin
                    t.ms_10 <= t.ms_10 + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stopwatch_lap_commander.sv
// stopwatch_lap_commander: stopwatch FSM, lap buffer and display mux over stopwatch_timebase.
// LAP_OVERWRITE_EN: when defined, a capture into a full buffer overwrites the oldest lap.
module stopwatch_lap_commander
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = 100000,
    parameter int LAP_DEPTH = 8,
    parameter int MIN_MAX   = 59,
    localparam int LAP_AW   = $clog2(LAP_DEPTH)
) (
    input  logic              clk_core,
    input  logic              rst,
    input  logic              pause,
    input  logic              record,
    input  logic              recall,
    output logic [5:0]        min_o,
    output logic [5:0]        sec_o,
    output logic [6:0]        ms_10_o,
    output logic [LAP_AW:0]   lap_cnt_o,
    output logic [LAP_AW-1:0] lap_idx_o,
    output logic              lap_full_o,
    output logic              lap_drop_o,
    output logic              running_o,
    output logic [2:0]        state_o
);

    state_t              state, nxt;
    time_t               t, split, disp;
    time_t               laps [LAP_DEPTH];
    logic [LAP_AW-1:0]   wptr, idx, rd, wnext, step;
    logic [LAP_AW:0]     cnt, sum, wrap;
    logic                drop, full, cap, clr, en;

    stopwatch_timebase #(.TICK_DIV(TICK_DIV), .MIN_MAX(MIN_MAX)) u_timebase (
        .clk   (clk_core),
        .rst_n (rst),
        .en    (en),
        .clr   (clr),
        .t     (t)
    );

    always_comb begin
        nxt = state;
        cap = 1'b0;
        clr = 1'b0;
        case (state)
            IDLE:       if (pause) nxt = RUN;
            RUN, SPLIT: if (pause) nxt = STOP;
                        else if (record) begin nxt = SPLIT; cap = 1'b1; end
            STOP:       if (pause) nxt = RUN;
                        else if (record) begin nxt = IDLE; clr = 1'b1; end
                        else if (recall && cnt != '0) nxt = RECALL;
            RECALL:     if (pause || record) nxt = STOP;
            default:    nxt = IDLE;
        endcase
    end

    assign en    = (state == RUN) || (state == SPLIT);
    assign full  = cnt == (LAP_AW+1)'(LAP_DEPTH);
    assign wnext = (wptr == LAP_AW'(LAP_DEPTH - 1)) ? '0 : wptr + 1'b1;
    assign step  = ({1'b0, idx} == cnt - 1'b1) ? '0 : idx + 1'b1;
    // Once full, the oldest lap sits at the write pointer.
    assign sum   = {1'b0, wptr} + {1'b0, idx};
    assign wrap  = sum - (LAP_AW+1)'(LAP_DEPTH);
    assign rd    = !full ? idx : (sum >= (LAP_AW+1)'(LAP_DEPTH)) ? wrap[LAP_AW-1:0] : sum[LAP_AW-1:0];

    always_ff @(posedge clk_core or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            wptr  <= '0;
            idx   <= '0;
            cnt   <= '0;
            drop  <= 1'b0;
            split <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) laps[i] <= '0;
        end else begin
            state <= nxt;
            drop  <= 1'b0;
            idx   <= (nxt != RECALL) ? '0 : (state == RECALL && recall) ? step : idx;
            if (clr) begin
                wptr  <= '0;
                cnt   <= '0;
                split <= '0;
                for (int i = 0; i < LAP_DEPTH; i++) laps[i] <= '0;
            end
            if (cap) begin
                split <= t;
`ifdef LAP_OVERWRITE_EN
                laps[wptr] <= t;
                wptr       <= wnext;
                if (full) drop <= 1'b1;
                else cnt <= cnt + 1'b1;
`else
                if (full) begin
                    drop <= 1'b1;
                end else begin
                    laps[wptr] <= t;
                    wptr       <= wnext;
                    cnt        <= cnt + 1'b1;
                end
`endif
            end
        end
    end

    assign disp       = (state == SPLIT) ? split : (state == RECALL) ? laps[rd] : t;
    assign min_o      = disp.min;
    assign sec_o      = disp.sec;
    assign ms_10_o    = disp.ms_10;
    assign lap_cnt_o  = cnt;
    assign lap_idx_o  = (state == RECALL) ? idx : '0;
    assign lap_full_o = full;
    assign lap_drop_o = drop;
    assign running_o  = en;
    assign state_o    = state;

endmodule

// File: tb/tb_stopwatch_lap_commander.sv
// tb_stopwatch_lap_commander: directed checks of counting, laps, recall, wrap and async reset.
module tb_stopwatch_lap_commander;

    localparam int TD = 2;
    localparam int LD = 4;
    localparam int MM = 1;
    localparam int AW = $clog2(LD);

    logic          clk = 1'b0;
    logic          rst;
    logic          pause, record, recall;
    logic [5:0]    min_o, sec_o;
    logic [6:0]    ms_10_o;
    logic [AW:0]   lap_cnt_o;
    logic [AW-1:0] lap_idx_o;
    logic          lap_full_o, lap_drop_o, running_o;
    logic [2:0]    state_o;

    int checks = 0;
    int errors = 0;

    int rec_idx [4] = '{0, 1, 2, 0};
    int rec_ms  [4] = '{10, 25, 40, 10};
`ifdef LAP_OVERWRITE_EN
    int full_ms [4] = '{25, 40, 41, 50};
`else
    int full_ms [4] = '{10, 25, 40, 41};
`endif

    stopwatch_lap_commander #(.TICK_DIV(TD), .LAP_DEPTH(LD), .MIN_MAX(MM)) dut (
        .clk_core   (clk),
        .rst        (rst),
        .pause      (pause),
        .record     (record),
        .recall     (recall),
        .min_o      (min_o),
        .sec_o      (sec_o),
        .ms_10_o    (ms_10_o),
        .lap_cnt_o  (lap_cnt_o),
        .lap_idx_o  (lap_idx_o),
        .lap_full_o (lap_full_o),
        .lap_drop_o (lap_drop_o),
        .running_o  (running_o),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Called at a negedge; holds the pulse across exactly one posedge.
    task automatic pulse(input logic [2:0] p);
        {pause, record, recall} = p;
        @(negedge clk);
        {pause, record, recall} = 3'b000;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        {pause, record, recall} = 3'b000;
        step(3);
        rst = 1'b1;
        step(20);
        check("rst_state", state_o, 0);
        check("rst_min", min_o, 0);
        check("rst_sec", sec_o, 0);
        check("rst_ms", ms_10_o, 0);
        check("rst_cnt", lap_cnt_o, 0);
        check("rst_idx", lap_idx_o, 0);
        check("rst_full", lap_full_o, 0);
        check("rst_drop", lap_drop_o, 0);
        check("rst_run", running_o, 0);

        pulse(3'b100);
        check("run_state", state_o, 1);
        check("run_running", running_o, 1);
        step(199);
        pulse(3'b100);
        check("stop_state", state_o, 3);
        check("stop_sec", sec_o, 1);
        check("stop_ms", ms_10_o, 0);
        step(50);
        check("hold_sec", sec_o, 1);
        check("hold_ms", ms_10_o, 0);
        check("hold_run", running_o, 0);
        pulse(3'b010);
        check("clr_state", state_o, 0);
        check("clr_sec", sec_o, 0);

        pulse(3'b100);
        pulse(3'b110);
        check("prio_state", state_o, 3);
        check("prio_cnt", lap_cnt_o, 0);
        check("prio_drop", lap_drop_o, 0);
        pulse(3'b010);
        check("prio_clr", state_o, 0);

        pulse(3'b100);
        step(20);
        pulse(3'b010);
        check("lap1_state", state_o, 2);
        check("lap1_ms", ms_10_o, 10);
        check("lap1_cnt", lap_cnt_o, 1);
        step(29);
        pulse(3'b010);
        check("lap2_ms", ms_10_o, 25);
        check("lap2_cnt", lap_cnt_o, 2);
        step(29);
        pulse(3'b010);
        check("lap3_ms", ms_10_o, 40);
        check("lap3_cnt", lap_cnt_o, 3);
        check("lap3_full", lap_full_o, 0);
        pulse(3'b100);
        check("split_stop", state_o, 3);
        check("live_ms", ms_10_o, 41);
        for (int i = 0; i < 4; i++) begin
            pulse(3'b001);
            check("rec_state", state_o, 4);
            check("rec_idx", lap_idx_o, rec_idx[i]);
            check("rec_ms", ms_10_o, rec_ms[i]);
        end
        check("rec_cnt", lap_cnt_o, 3);
        pulse(3'b100);
        check("rec_exit", state_o, 3);
        check("rec_live", ms_10_o, 41);

        pulse(3'b100);
        pulse(3'b010);
        check("lap4_ms", ms_10_o, 41);
        check("lap4_full", lap_full_o, 1);
        check("lap4_drop", lap_drop_o, 0);
        step(17);
        pulse(3'b010);
        check("lap5_drop", lap_drop_o, 1);
        check("lap5_ms", ms_10_o, 50);
        check("lap5_cnt", lap_cnt_o, 4);
        check("lap5_full", lap_full_o, 1);
        step(1);
        check("drop_once", lap_drop_o, 0);
        pulse(3'b100);
        for (int i = 0; i < 4; i++) begin
            pulse(3'b001);
            check("full_idx", lap_idx_o, i);
            check("full_ms", ms_10_o, full_ms[i]);
        end
        pulse(3'b010);
        check("rec_rec_stop", state_o, 3);
        pulse(3'b010);
        check("wipe_state", state_o, 0);
        check("wipe_cnt", lap_cnt_o, 0);
        check("wipe_full", lap_full_o, 0);
        check("wipe_ms", ms_10_o, 0);

        pulse(3'b100);
        step(23998);
        check("top_min", min_o, 1);
        check("top_sec", sec_o, 59);
        check("top_ms", ms_10_o, 99);
        step(1);
        check("top_hold", ms_10_o, 99);
        step(1);
        check("wrap_min", min_o, 0);
        check("wrap_sec", sec_o, 0);
        check("wrap_ms", ms_10_o, 0);
        check("wrap_run", running_o, 1);

        pulse(3'b010);
        check("ar_split", state_o, 2);
        check("ar_cnt1", lap_cnt_o, 1);
        #2 rst = 1'b0;
        #1;
        check("ar_state", state_o, 0);
        check("ar_ms", ms_10_o, 0);
        check("ar_cnt", lap_cnt_o, 0);
        check("ar_run", running_o, 0);
        @(negedge clk);
        rst = 1'b1;
        step(2);
        check("ar_after", state_o, 0);
        check("ar_after_cnt", lap_cnt_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
